coin_collector: RTL and testbench
=================================

COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 Parameter TIMEOUT, default 15, is the number of idle cycles in COLLECT before an automatic refund; legal range 1..31.
REQ-002 clk  input  1  single system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 coinValid  input  1  one coin presented this cycle.
REQ-005 coinType  input  2  coin type: 00=NTD_50, 01=NTD_10, 10=NTD_5, 11=NTD_1.
REQ-006 selValid  input  1  item-select strobe.
REQ-007 itemSel  input  2  item code: 00=NONE, 01=A, 10=B, 11=C.
REQ-008 cancel  input  1  customer abort request.
REQ-009 serviceTypeIn  input  2  downstream vending-machine state: 00=OFF, 01=ON, 10=BUSY.
REQ-010 coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1  output  2 each  coin counts handed to the vending machine.
REQ-011 itemTypeIn  output  2  item request to the vending machine; 00 when no request.
REQ-012 insertedValue  output  8  running value of held coins.
REQ-013 refundValid  output  1  one-cycle pulse; refundValue is valid while it is high.
REQ-014 refundValue  output  8  value returned to the customer.
REQ-015 coinReject  output  1  one-cycle pulse, the cycle after a rejected coin.
REQ-016 busy  output  1  high in ISSUE and WAIT.

Function
REQ-017 The FSM SHALL have four states: IDLE=00, COLLECT=01, ISSUE=10, WAIT=11.
REQ-018 The block SHALL hold four internal 2-bit counters, cnt50, cnt10, cnt5 and cnt1; each increments on an accepted coin of its type and saturates at 3.
REQ-019 insertedValue SHALL be the registered value 50*cnt50 + 10*cnt10 + 5*cnt5 + cnt1; the maximum is 198, so there is no overflow.
REQ-020 In IDLE, an accepted coin SHALL increment its counter and move to COLLECT; selValid and cancel are ignored while all counters are 0.
REQ-021 A coin SHALL be rejected when its counter is already 3, or when the state is ISSUE or WAIT; a rejected coin leaves the counters unchanged and raises coinReject for one cycle.
REQ-022 COLLECT priority, same cycle: cancel > timeout > selValid > coinValid; the lower-priority events in that cycle are dropped, and a dropped coin raises coinReject.
REQ-023 In COLLECT, cancel or timeout SHALL do all of the following on the next cycle: pulse refundValid with refundValue = insertedValue, clear the counters, reset the timer, and return to IDLE.
REQ-024 The 5-bit idle timer SHALL clear on entry to COLLECT and on each accepted coin, and increment otherwise; timeout fires when the timer equals TIMEOUT.
REQ-025 In COLLECT, selValid with itemSel != 00 SHALL latch itemSel and go to ISSUE; selValid with itemSel == 00 is ignored.
REQ-026 In ISSUE, coinInNTD_* SHALL equal the counters and itemTypeIn the latched item; in every other state they are all 0.
REQ-027 Handoff SHALL occur at the first posedge in ISSUE where serviceTypeIn == 01; on that edge the state goes to WAIT, and the counters, insertedValue and the coin/item outputs clear to 0.
REQ-028 In ISSUE with serviceTypeIn != 01, cancel SHALL refund exactly as in REQ-023; if serviceTypeIn == 01 in the same cycle, the handoff wins and no refund occurs.
REQ-029 The timer SHALL NOT run in ISSUE or WAIT.
REQ-030 WAIT SHALL return to IDLE on the first posedge where serviceTypeIn == 00, which marks vending-machine completion.
REQ-031 selValid and cancel SHALL be ignored in WAIT.
REQ-032 refundValid and coinReject SHALL be registered, never asserted together with a handoff edge, and 0 in all other cycles.

Reset
REQ-033 While reset = 0, the block SHALL immediately force: state=IDLE, all counters/timer/latched item = 0, every output = 0.
REQ-034 Reset asserted mid-operation, in any state, SHALL discard the held coins without a refund pulse.
REQ-035 The first posedge after reset deassertion SHALL sample inputs normally.

Verification
REQ-036 Scenario 1, coins then select: coins 50, 10, 1, then selValid with itemSel=01 and serviceTypeIn=01 -> insertedValue=61; ISSUE outputs are coinInNTD_50=1, coinInNTD_10=1, coinInNTD_1=1, itemTypeIn=01; the next cycle is WAIT with outputs 0.
REQ-037 Scenario 2, saturation: four NTD_5 coins -> cnt5=3, insertedValue=15; coinReject pulses once after the fourth coin.
REQ-038 Scenario 3, cancel: coins 10 and 5, then cancel -> refundValid=1 for one cycle with refundValue=15; state returns to IDLE with insertedValue=0.
REQ-039 Scenario 4, timeout: TIMEOUT=4, one NTD_1 coin, then no activity -> refundValid with refundValue=1 exactly 5 cycles after the coin cycle.
REQ-040 Scenario 5, stalled handoff: ISSUE with serviceTypeIn=10 for 3 cycles, then 01, then BUSY, then 00 -> outputs held for 4 cycles, then WAIT, then IDLE after 00 is seen; a coin presented during WAIT is rejected.
REQ-041 Scenario 6, reset mid-ISSUE: reset asserted during ISSUE -> all outputs 0 asynchronously and no refundValid pulse.

Source files
------------

// File: rtl/coin_collector_if.sv
// Signal bundle between the customer/vending-machine side and coin_collector.
// master drives the customer and machine inputs; slave is the collector itself.
interface coin_collector_if;
    logic       coinValid;
    logic [1:0] coinType;
    logic       selValid;
    logic [1:0] itemSel;
    logic       cancel;
    logic [1:0] serviceTypeIn;
    logic [1:0] coinInNTD_50;
    logic [1:0] coinInNTD_10;
    logic [1:0] coinInNTD_5;
    logic [1:0] coinInNTD_1;
    logic [1:0] itemTypeIn;
    logic [7:0] insertedValue;
    logic       refundValid;
    logic [7:0] refundValue;
    logic       coinReject;
    logic       busy;
    logic [1:0] fsmState;

    modport master (
        output coinValid, coinType, selValid, itemSel, cancel, serviceTypeIn,
        input  coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn,
        input  insertedValue, refundValid, refundValue, coinReject, busy, fsmState
    );

    modport slave (
        input  coinValid, coinType, selValid, itemSel, cancel, serviceTypeIn,
        output coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn,
        output insertedValue, refundValid, refundValue, coinReject, busy, fsmState
    );
endinterface

// File: rtl/coin_collector.sv
// Coin collector: counts inserted coins, hands them with an item request to the
// vending machine, and refunds on cancel or idle timeout. fsmState exposes the FSM.
module coin_collector #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic             clk,
    input logic             reset,
    coin_collector_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        ISSUE   = 2'b10,
        WAIT    = 2'b11
    } state_t;

    localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);

    state_t          state_q, state_d;
    // Counter index follows coinType: 0=NTD_50, 1=NTD_10, 2=NTD_5, 3=NTD_1.
    logic [3:0][1:0] cnt_q, cnt_d;
    logic [4:0]      timer_q, timer_d;
    logic [1:0]      item_q, item_d;
    logic [7:0]      value_q, value_d;
    logic            refund_valid_q, refund_valid_d;
    logic [7:0]      refund_value_q, refund_value_d;
    logic            coin_reject_q, coin_reject_d;

    logic coin_room;
    logic timeout;
    logic issue;

    assign coin_room = (cnt_q[bus.coinType] != 2'd3);
    assign timeout   = (timer_q == TIMEOUT_C);
    assign issue     = (state_q == ISSUE);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        timer_d        = timer_q;
        item_d         = item_q;
        refund_valid_d = 1'b0;
        refund_value_d = 8'd0;
        coin_reject_d  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = 5'd0;
                if (bus.coinValid) begin
                    if (coin_room) begin
                        cnt_d[bus.coinType] = cnt_q[bus.coinType] + 2'd1;
                        state_d             = COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.cancel || timeout) begin
                    refund_valid_d = 1'b1;
                    refund_value_d = value_q;
                    cnt_d          = '0;
                    timer_d        = 5'd0;
                    state_d        = IDLE;
                    coin_reject_d  = bus.coinValid;
                end else if (bus.selValid && (bus.itemSel != 2'b00)) begin
                    item_d        = bus.itemSel;
                    state_d       = ISSUE;
                    coin_reject_d = bus.coinValid;
                end else if (bus.coinValid && coin_room) begin
                    cnt_d[bus.coinType] = cnt_q[bus.coinType] + 2'd1;
                    timer_d             = 5'd0;
                end else begin
                    coin_reject_d = bus.coinValid;
                    timer_d       = timer_q + 5'd1;
                end
            end
            ISSUE: begin
                // Handoff beats cancel, and the handoff edge carries no pulses.
                if (bus.serviceTypeIn == 2'b01) begin
                    cnt_d   = '0;
                    item_d  = 2'b00;
                    timer_d = 5'd0;
                    state_d = WAIT;
                end else begin
                    coin_reject_d = bus.coinValid;
                    if (bus.cancel) begin
                        refund_valid_d = 1'b1;
                        refund_value_d = value_q;
                        cnt_d          = '0;
                        item_d         = 2'b00;
                        timer_d        = 5'd0;
                        state_d        = IDLE;
                    end
                end
            end
            WAIT: begin
                coin_reject_d = bus.coinValid;
                if (bus.serviceTypeIn == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        value_d = 8'd50 * {6'd0, cnt_d[0]} + 8'd10 * {6'd0, cnt_d[1]}
                + 8'd5 * {6'd0, cnt_d[2]} + {6'd0, cnt_d[3]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            timer_q        <= 5'd0;
            item_q         <= 2'b00;
            value_q        <= 8'd0;
            refund_valid_q <= 1'b0;
            refund_value_q <= 8'd0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timer_q        <= timer_d;
            item_q         <= item_d;
            value_q        <= value_d;
            refund_valid_q <= refund_valid_d;
            refund_value_q <= refund_value_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign bus.coinInNTD_50  = issue ? cnt_q[0] : 2'd0;
    assign bus.coinInNTD_10  = issue ? cnt_q[1] : 2'd0;
    assign bus.coinInNTD_5   = issue ? cnt_q[2] : 2'd0;
    assign bus.coinInNTD_1   = issue ? cnt_q[3] : 2'd0;
    assign bus.itemTypeIn    = issue ? item_q : 2'b00;
    assign bus.insertedValue = value_q;
    assign bus.refundValid   = refund_valid_q;
    assign bus.refundValue   = refund_value_q;
    assign bus.coinReject    = coin_reject_q;
    assign bus.busy          = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.fsmState      = state_q;
endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector (TIMEOUT=4): one task per scenario with
// hand-computed expectations, then a single summary line.
module tb_coin_collector;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    coin_collector_if bus ();

    coin_collector #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.coinValid = 1'b0;
        bus.coinType  = 2'b00;
        bus.selValid  = 1'b0;
        bus.itemSel   = 2'b00;
        bus.cancel    = 1'b0;
    endtask

    task automatic drive_coin(input logic [1:0] t);
        bus.coinValid = 1'b1;
        bus.coinType  = t;
        step();
        bus.coinValid = 1'b0;
    endtask

    task automatic drive_select(input logic [1:0] item);
        bus.selValid = 1'b1;
        bus.itemSel  = item;
        step();
        bus.selValid = 1'b0;
        bus.itemSel  = 2'b00;
    endtask

    task automatic drive_cancel();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        bus.serviceTypeIn = 2'b00;
        step();
        step();
        n_cmp++;
        if (bus.fsmState !== 2'b00) begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus.fsmState); end
        n_cmp++;
        if (bus.insertedValue !== 8'd0) begin n_bad++; $display("FAIL rst_value: got %0d want 0", bus.insertedValue); end
        n_cmp++;
        if ({bus.refundValid, bus.coinReject, bus.busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_flags: got %b want 000", {bus.refundValid, bus.coinReject, bus.busy});
        end
        n_cmp++;
        if ({bus.coinInNTD_50, bus.coinInNTD_10, bus.coinInNTD_5, bus.coinInNTD_1, bus.itemTypeIn} !== 10'd0) begin
            n_bad++; $display("FAIL rst_outs: got %b want 0", {bus.coinInNTD_50, bus.coinInNTD_10, bus.coinInNTD_5, bus.coinInNTD_1, bus.itemTypeIn});
        end
        #2 reset = 1'b1;
        step();
        n_cmp++;
        if (bus.fsmState !== 2'b00) begin n_bad++; $display("FAIL rst_release_state: got %0d want 0", bus.fsmState); end
    endtask

    task automatic test_select();
        bus.serviceTypeIn = 2'b01;
        drive_coin(2'b00);
        n_cmp++;
        if (bus.fsmState !== 2'b01) begin n_bad++; $display("FAIL s1_collect: got %0d want 1", bus.fsmState); end
        drive_coin(2'b01);
        drive_coin(2'b11);
        n_cmp++;
        if (bus.insertedValue !== 8'd61) begin n_bad++; $display("FAIL s1_value: got %0d want 61", bus.insertedValue); end
        drive_select(2'b01);
        n_cmp++;
        if (bus.fsmState !== 2'b10) begin n_bad++; $display("FAIL s1_issue_state: got %0d want 2", bus.fsmState); end
        n_cmp++;
        if ({bus.coinInNTD_50, bus.coinInNTD_10, bus.coinInNTD_5, bus.coinInNTD_1} !== 8'b01_01_00_01) begin
            n_bad++; $display("FAIL s1_issue_coins: got %b want 01010001", {bus.coinInNTD_50, bus.coinInNTD_10, bus.coinInNTD_5, bus.coinInNTD_1});
        end
        n_cmp++;
        if (bus.itemTypeIn !== 2'b01) begin n_bad++; $display("FAIL s1_issue_item: got %b want 01", bus.itemTypeIn); end
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL s1_issue_busy: got %b want 1", bus.busy); end
        step();
        n_cmp++;
        if (bus.fsmState !== 2'b11) begin n_bad++; $display("FAIL s1_wait_state: got %0d want 3", bus.fsmState); end
        n_cmp++;
        if ({bus.coinInNTD_50, bus.coinInNTD_10, bus.coinInNTD_5, bus.coinInNTD_1, bus.itemTypeIn, bus.insertedValue} !== 18'd0) begin
            n_bad++; $display("FAIL s1_wait_outs: value %0d item %b want 0", bus.insertedValue, bus.itemTypeIn);
        end
        n_cmp++;
        if ({bus.refundValid, bus.coinReject} !== 2'b00) begin
            n_bad++; $display("FAIL s1_handoff_pulses: got %b want 00", {bus.refundValid, bus.coinReject});
        end
        bus.serviceTypeIn = 2'b00;
        step();
        n_cmp++;
        if ({bus.fsmState, bus.busy} !== 3'b000) begin n_bad++; $display("FAIL s1_idle: got %b want 000", {bus.fsmState, bus.busy}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            drive_coin(2'b10);
        end
        n_cmp++;
        if (bus.insertedValue !== 8'd15) begin n_bad++; $display("FAIL s2_value: got %0d want 15", bus.insertedValue); end
        n_cmp++;
        if (bus.coinReject !== 1'b1) begin n_bad++; $display("FAIL s2_reject: got %b want 1", bus.coinReject); end
        step();
        n_cmp++;
        if (bus.coinReject !== 1'b0) begin n_bad++; $display("FAIL s2_reject_once: got %b want 0", bus.coinReject); end
        drive_cancel();
        n_cmp++;
        if ({bus.refundValid, bus.refundValue} !== {1'b1, 8'd15}) begin
            n_bad++; $display("FAIL s2_refund: valid %b value %0d want 1/15", bus.refundValid, bus.refundValue);
        end
        step();
    endtask

    task automatic test_cancel();
        drive_coin(2'b01);
        drive_coin(2'b10);
        n_cmp++;
        if (bus.insertedValue !== 8'd15) begin n_bad++; $display("FAIL s3_value: got %0d want 15", bus.insertedValue); end
        drive_cancel();
        n_cmp++;
        if ({bus.refundValid, bus.refundValue} !== {1'b1, 8'd15}) begin
            n_bad++; $display("FAIL s3_refund: valid %b value %0d want 1/15", bus.refundValid, bus.refundValue);
        end
        n_cmp++;
        if ({bus.fsmState, bus.insertedValue} !== 10'd0) begin
            n_bad++; $display("FAIL s3_idle: state %0d value %0d want 0/0", bus.fsmState, bus.insertedValue);
        end
        step();
        n_cmp++;
        if (bus.refundValid !== 1'b0) begin n_bad++; $display("FAIL s3_refund_pulse: got %b want 0", bus.refundValid); end
    endtask

    task automatic test_timeout();
        drive_coin(2'b11);
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if (bus.refundValid !== (k == 5)) begin
                n_bad++; $display("FAIL s4_timeout_edge%0d: got %b want %b", k, bus.refundValid, (k == 5));
            end
        end
        n_cmp++;
        if ({bus.refundValue, bus.fsmState} !== {8'd1, 2'b00}) begin
            n_bad++; $display("FAIL s4_refund: value %0d state %0d want 1/0", bus.refundValue, bus.fsmState);
        end
        step();
    endtask

    task automatic test_stalled();
        bus.serviceTypeIn = 2'b10;
        drive_coin(2'b00);
        drive_coin(2'b10);
        drive_select(2'b11);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.fsmState, bus.coinInNTD_50, bus.coinInNTD_5, bus.itemTypeIn, bus.insertedValue} !== {2'b10, 2'd1, 2'd1, 2'b11, 8'd55}) begin
                n_bad++; $display("FAIL s5_held%0d: state %0d c50 %0d c5 %0d item %b value %0d", i,
                                  bus.fsmState, bus.coinInNTD_50, bus.coinInNTD_5, bus.itemTypeIn, bus.insertedValue);
            end
            if (i == 3) bus.serviceTypeIn = 2'b01;
            step();
        end
        n_cmp++;
        if ({bus.fsmState, bus.coinInNTD_50, bus.coinInNTD_5, bus.itemTypeIn} !== {2'b11, 6'd0}) begin
            n_bad++; $display("FAIL s5_wait: state %0d item %b", bus.fsmState, bus.itemTypeIn);
        end
        bus.serviceTypeIn = 2'b10;
        bus.cancel        = 1'b1;
        drive_coin(2'b01);
        bus.cancel = 1'b0;
        n_cmp++;
        if ({bus.fsmState, bus.coinReject, bus.refundValid, bus.insertedValue} !== {2'b11, 1'b1, 1'b0, 8'd0}) begin
            n_bad++; $display("FAIL s5_wait_reject: state %0d reject %b refund %b value %0d",
                              bus.fsmState, bus.coinReject, bus.refundValid, bus.insertedValue);
        end
        bus.serviceTypeIn = 2'b00;
        step();
        n_cmp++;
        if ({bus.fsmState, bus.coinReject} !== 3'b000) begin
            n_bad++; $display("FAIL s5_idle: state %0d reject %b", bus.fsmState, bus.coinReject);
        end
    endtask

    task automatic test_issue_cancel();
        bus.serviceTypeIn = 2'b10;
        drive_coin(2'b01);
        drive_select(2'b01);
        drive_cancel();
        n_cmp++;
        if ({bus.refundValid, bus.refundValue, bus.fsmState} !== {1'b1, 8'd10, 2'b00}) begin
            n_bad++; $display("FAIL issue_cancel: valid %b value %0d state %0d want 1/10/0",
                              bus.refundValid, bus.refundValue, bus.fsmState);
        end
        drive_coin(2'b11);
        drive_select(2'b10);
        bus.cancel        = 1'b1;
        bus.serviceTypeIn = 2'b01;
        step();
        bus.cancel = 1'b0;
        n_cmp++;
        if ({bus.fsmState, bus.refundValid} !== {2'b11, 1'b0}) begin
            n_bad++; $display("FAIL handoff_beats_cancel: state %0d refund %b want 3/0", bus.fsmState, bus.refundValid);
        end
        bus.serviceTypeIn = 2'b00;
        step();
    endtask

    task automatic test_priority();
        bus.serviceTypeIn = 2'b10;
        drive_coin(2'b00);
        bus.cancel = 1'b1;
        drive_coin(2'b10);
        bus.cancel = 1'b0;
        n_cmp++;
        if ({bus.refundValid, bus.refundValue, bus.coinReject} !== {1'b1, 8'd50, 1'b1}) begin
            n_bad++; $display("FAIL cancel_over_coin: valid %b value %0d reject %b want 1/50/1",
                              bus.refundValid, bus.refundValue, bus.coinReject);
        end
        drive_coin(2'b01);
        drive_select(2'b00);
        n_cmp++;
        if (bus.fsmState !== 2'b01) begin n_bad++; $display("FAIL sel_none_ignored: got %0d want 1", bus.fsmState); end
        bus.selValid = 1'b1;
        bus.itemSel  = 2'b01;
        drive_coin(2'b10);
        bus.selValid = 1'b0;
        bus.itemSel  = 2'b00;
        n_cmp++;
        if ({bus.fsmState, bus.insertedValue, bus.coinReject, bus.coinInNTD_5} !== {2'b10, 8'd10, 1'b1, 2'd0}) begin
            n_bad++; $display("FAIL sel_over_coin: state %0d value %0d reject %b c5 %0d",
                              bus.fsmState, bus.insertedValue, bus.coinReject, bus.coinInNTD_5);
        end
        drive_cancel();
        step();
    endtask

    task automatic test_reset_mid_issue();
        bus.serviceTypeIn = 2'b10;
        drive_coin(2'b00);
        drive_select(2'b01);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fsmState, bus.busy, bus.insertedValue, bus.coinInNTD_50, bus.itemTypeIn, bus.refundValid} !== 16'd0) begin
            n_bad++; $display("FAIL s6_async_clear: state %0d busy %b value %0d c50 %0d item %b",
                              bus.fsmState, bus.busy, bus.insertedValue, bus.coinInNTD_50, bus.itemTypeIn);
        end
        step();
        n_cmp++;
        if ({bus.refundValid, bus.refundValue} !== 9'd0) begin
            n_bad++; $display("FAIL s6_no_refund: valid %b value %0d", bus.refundValid, bus.refundValue);
        end
        bus.coinValid = 1'b1;
        bus.coinType  = 2'b01;
        reset         = 1'b1;
        step();
        bus.coinValid = 1'b0;
        n_cmp++;
        if ({bus.fsmState, bus.insertedValue} !== {2'b01, 8'd10}) begin
            n_bad++; $display("FAIL s6_first_edge: state %0d value %0d want 1/10", bus.fsmState, bus.insertedValue);
        end
        drive_cancel();
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_select();
        test_saturation();
        test_cancel();
        test_timeout();
        test_stalled();
        test_issue_cancel();
        test_priority();
        test_reset_mid_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
